// File: rtl/halt_dump_ctrl_if.sv
// Halt/dump controller bus: CPU fetch and run, RAM read port, dump stream.
// master = controller side, slave = CPU/RAM/consumer side.
interface halt_dump_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9
);
  logic [31:0]       instr_f;
  logic              cpu_run;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic              dump_valid;
  logic              dump_ready;
  logic [DATA_W-1:0] dump_data;
  logic [ADDR_W-1:0] dump_addr;
  logic              dump_last;
  logic              done;
  logic              timeout;
  logic [31:0]       cycle_count;

  modport master (
    input  instr_f, mem_rd_data, dump_ready,
    output cpu_run, mem_rd_en, mem_rd_addr,
    output dump_valid, dump_data, dump_addr,
    output dump_last, done, timeout, cycle_count
  );

  modport slave (
    output instr_f, mem_rd_data, dump_ready,
    input  cpu_run, mem_rd_en, mem_rd_addr,
    input  dump_valid, dump_data, dump_addr,
    input  dump_last, done, timeout, cycle_count
  );
endinterface

// File: rtl/halt_dump_ctrl.sv
// Runs the CPU until the halt sentinel, drains, then streams the data RAM out.
// Ports: CLOCK, RESET (sync, active low), bus (halt_dump_ctrl_if.master).
module halt_dump_ctrl #(
  parameter int          DATA_W       = 32,
  parameter int          ADDR_W       = 9,
  parameter int          DUMP_WORDS   = 512,
  parameter int          DRAIN_CYCLES = 10,
  parameter int          MAX_CYCLES   = 600,
  parameter logic [31:0] HALT_WORD    = 32'hFFFF_FFFF
) (
  input logic               CLOCK,
  input logic               RESET,
  halt_dump_ctrl_if.master  bus
);
  typedef enum logic [2:0] {
    RUN, DRAIN, DUMP_RD, DUMP_CAP, DUMP_OUT, DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(DUMP_WORDS - 1);
  localparam logic [7:0]  DRAIN_INIT = 8'(DRAIN_CYCLES);
  localparam logic [31:0] CYC_LIM = 32'(MAX_CYCLES - 1);
  localparam bit          HAS_LIM = (MAX_CYCLES != 0);
  localparam bit          NO_DRAIN = (DRAIN_CYCLES == 0);

  state_t            state, state_n;
  logic [31:0]       cyc;
  logic [7:0]        dcnt;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] daddr;
  logic [DATA_W-1:0] ddata;
  logic              to_q;
  logic              halt, lim, accept;
  logic              run_o, rd_o, vld_o;

  assign halt   = (bus.instr_f == HALT_WORD);
  assign lim    = HAS_LIM && (cyc == CYC_LIM);
  assign accept = (state == DUMP_OUT) && bus.dump_ready;

  always_ff @(posedge CLOCK) begin
    if (!RESET) state <= RUN;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      RUN: begin
        if (halt)
          state_n = NO_DRAIN ? DUMP_RD : DRAIN;
        else if (lim)
          state_n = DONE;
      end
      DRAIN:    if (dcnt <= 8'd1) state_n = DUMP_RD;
      DUMP_RD:  state_n = DUMP_CAP;
      DUMP_CAP: state_n = DUMP_OUT;
      DUMP_OUT: begin
        if (accept)
          state_n = (daddr == LAST) ? DONE : DUMP_RD;
      end
      DONE:     state_n = DONE;
      default:  state_n = RUN;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      cyc   <= '0;
      dcnt  <= '0;
      addr  <= '0;
      daddr <= '0;
      ddata <= '0;
      to_q  <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (cyc != '1) cyc <= cyc + 32'd1;
          if (halt) begin
            dcnt <= DRAIN_INIT;
            addr <= '0;
          end else if (lim) begin
            to_q <= 1'b1;
          end
        end
        DRAIN:    dcnt <= dcnt - 8'd1;
        DUMP_CAP: begin
          ddata <= bus.mem_rd_data;
          daddr <= addr;
        end
        DUMP_OUT: begin
          if (accept && daddr != LAST)
            addr <= addr + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    run_o = 1'b0;
    rd_o  = 1'b0;
    vld_o = 1'b0;
    unique case (state)
      RUN, DRAIN: run_o = 1'b1;
      DUMP_RD:    rd_o  = 1'b1;
      DUMP_OUT:   vld_o = 1'b1;
      default: ;
    endcase
  end

  // Outputs are forced to reset values while RESET is low,
  // not only after the reset edge.
  assign bus.cpu_run     = run_o | ~RESET;
  assign bus.mem_rd_en   = rd_o & RESET;
  assign bus.mem_rd_addr = RESET ? addr : '0;
  assign bus.dump_valid  = vld_o & RESET;
  assign bus.dump_last   = vld_o & RESET & (daddr == LAST);
  assign bus.dump_data   = RESET ? ddata : '0;
  assign bus.dump_addr   = RESET ? daddr : '0;
  assign bus.done        = RESET & (state == DONE);
  assign bus.timeout     = RESET & to_q;
  assign bus.cycle_count = cyc;
endmodule

// File: tb/tb_halt_dump_ctrl.sv
// Bench for halt_dump_ctrl: two configurations, random stimulus,
// per-cycle check against a transaction-level reference model.
module tb_halt_dump_ctrl;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic        clk;
  logic        rstn [2];
  logic [31:0] instr [2];
  logic        ready [2];
  logic [31:0] rdata [2];
  logic [31:0] ram [512];

  logic        o_cpu_run [2];
  logic        o_rd_en [2];
  logic [8:0]  o_rd_addr [2];
  logic        o_valid [2];
  logic [31:0] o_data [2];
  logic [8:0]  o_addr [2];
  logic        o_last [2];
  logic        o_done [2];
  logic        o_to [2];
  logic [31:0] o_cc [2];

  int n_cmp = 0;
  int n_bad = 0;

  int unsigned m_run [2];
  bit m_h [2];
  bit m_f [2];
  bit m_t [2];
  int m_d [2];
  int m_w [2];
  int m_k [2];

  function automatic int pdrain(input int i);
    return (i == 0) ? 10 : 0;
  endfunction
  function automatic int pwords(input int i);
    return (i == 0) ? 512 : 4;
  endfunction
  function automatic int pmax(input int i);
    return (i == 0) ? 600 : 50;
  endfunction
  function automatic logic [31:0] nohalt();
    return $urandom & 32'hFFFF_FFFE;
  endfunction

  halt_dump_ctrl_if #(.DATA_W(32), .ADDR_W(9)) ifa ();
  halt_dump_ctrl_if #(.DATA_W(32), .ADDR_W(9)) ifb ();

  halt_dump_ctrl #(
    .DATA_W(32), .ADDR_W(9), .DUMP_WORDS(512),
    .DRAIN_CYCLES(10), .MAX_CYCLES(600), .HALT_WORD(HALT)
  ) dut_a (.CLOCK(clk), .RESET(rstn[0]), .bus(ifa.master));

  halt_dump_ctrl #(
    .DATA_W(32), .ADDR_W(9), .DUMP_WORDS(4),
    .DRAIN_CYCLES(0), .MAX_CYCLES(50), .HALT_WORD(HALT)
  ) dut_b (.CLOCK(clk), .RESET(rstn[1]), .bus(ifb.master));

  assign ifa.instr_f     = instr[0];
  assign ifa.dump_ready  = ready[0];
  assign ifa.mem_rd_data = rdata[0];
  assign ifb.instr_f     = instr[1];
  assign ifb.dump_ready  = ready[1];
  assign ifb.mem_rd_data = rdata[1];

  assign o_cpu_run[0] = ifa.cpu_run;
  assign o_rd_en[0]   = ifa.mem_rd_en;
  assign o_rd_addr[0] = ifa.mem_rd_addr;
  assign o_valid[0]   = ifa.dump_valid;
  assign o_data[0]    = ifa.dump_data;
  assign o_addr[0]    = ifa.dump_addr;
  assign o_last[0]    = ifa.dump_last;
  assign o_done[0]    = ifa.done;
  assign o_to[0]      = ifa.timeout;
  assign o_cc[0]      = ifa.cycle_count;
  assign o_cpu_run[1] = ifb.cpu_run;
  assign o_rd_en[1]   = ifb.mem_rd_en;
  assign o_rd_addr[1] = ifb.mem_rd_addr;
  assign o_valid[1]   = ifb.dump_valid;
  assign o_data[1]    = ifb.dump_data;
  assign o_addr[1]    = ifb.dump_addr;
  assign o_last[1]    = ifb.dump_last;
  assign o_done[1]    = ifb.done;
  assign o_to[1]      = ifb.timeout;
  assign o_cc[1]      = ifb.cycle_count;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data RAM with one-cycle read latency.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++)
      if (o_rd_en[i]) rdata[i] <= ram[o_rd_addr[i]];
  end

  task automatic chk(input string nm, input int i,
                     input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      if (n_bad < 40)
        $display("FAIL %s dut%0d: got %0h want %0h",
                 nm, i, act, exp);
    end
  endtask

  // Reference model: RUN cycles counted, then drain length,
  // then each word = read, capture, offer until accepted.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int unsigned r;
      bit h, f, t;
      int d, w, k;
      r = m_run[i]; h = m_h[i]; f = m_f[i]; t = m_t[i];
      d = m_d[i]; w = m_w[i]; k = m_k[i];
      if (!rstn[i]) begin
        r = 0; h = 0; f = 0; t = 0; d = 0; w = 0; k = 0;
      end else if (!f) begin
        if (!h) begin
          r = r + 1;
          if (instr[i] == HALT) begin
            h = 1; d = 0;
          end else if (pmax(i) != 0 && r == pmax(i)) begin
            f = 1; t = 1;
          end
        end else if (d < pdrain(i)) begin
          d = d + 1;
        end else if (k < 2) begin
          k = k + 1;
        end else if (ready[i]) begin
          if (w == pwords(i) - 1) f = 1;
          else begin
            w = w + 1; k = 0;
          end
        end
      end
      m_run[i] <= r; m_h[i] <= h; m_f[i] <= f; m_t[i] <= t;
      m_d[i] <= d; m_w[i] <= w; m_k[i] <= k;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      bit dmp, erun, erd, evld, elast;
      if (!rstn[i]) begin
        chk("rst_cpu_run", i, o_cpu_run[i], 1);
        chk("rst_rd_en", i, o_rd_en[i], 0);
        chk("rst_valid", i, o_valid[i], 0);
        chk("rst_last", i, o_last[i], 0);
        chk("rst_done", i, o_done[i], 0);
        chk("rst_timeout", i, o_to[i], 0);
        chk("rst_data", i, o_data[i], 0);
        chk("rst_addr", i, o_addr[i], 0);
        chk("rst_rd_addr", i, o_rd_addr[i], 0);
      end else begin
        dmp   = m_h[i] && !m_f[i] && m_d[i] >= pdrain(i);
        erun  = !m_f[i] && !dmp;
        erd   = dmp && m_k[i] == 0;
        evld  = dmp && m_k[i] >= 2;
        elast = evld && m_w[i] == pwords(i) - 1;
        chk("cpu_run", i, o_cpu_run[i], erun);
        chk("rd_en", i, o_rd_en[i], erd);
        chk("valid", i, o_valid[i], evld);
        chk("last", i, o_last[i], elast);
        chk("done", i, o_done[i], m_f[i]);
        chk("timeout", i, o_to[i], m_t[i]);
        chk("cycle_count", i, o_cc[i], m_run[i]);
        chk("rd_addr_range", i,
            (int'(o_rd_addr[i]) <= pwords(i) - 1), 1);
        if (erd) chk("rd_addr", i, o_rd_addr[i], m_w[i]);
        if (evld) begin
          chk("dump_data", i, o_data[i], ram[m_w[i]]);
          chk("dump_addr", i, o_addr[i], m_w[i]);
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic scn(input int i, input string tag,
                     input int halt_at, input bit rnd_ready,
                     input int rst_addr, input int exp_words,
                     input int exp_cc, input bit exp_to,
                     input int exp_gap, input int exp_runs);
    int cyc = 0;
    int hold = 0;
    int halt_cyc = -1;
    int gap = -1;
    int acc = 0;
    int lasts = 0;
    int runs = 0;
    int h = halt_at;
    bit halted = 0;
    bit rst_pend = 0;
    bit rst_used = (rst_addr < 0);
    rstn[i] = 0;
    ready[i] = 0;
    instr[i] = nohalt();
    step();
    chk({tag, "_init_run"}, i, o_cpu_run[i], 1);
    chk({tag, "_init_cc"}, i, o_cc[i], 0);
    chk({tag, "_init_done"}, i, o_done[i], 0);
    rstn[i] = 1;
    while (!o_done[i] && cyc < 20000) begin
      if (rst_pend) begin
        chk({tag, "_mid_rst_run"}, i, o_cpu_run[i], 1);
        chk({tag, "_mid_rst_vld"}, i, o_valid[i], 0);
        chk({tag, "_mid_rst_cc"}, i, o_cc[i], 0);
        rstn[i] = 1;
        rst_pend = 0;
        halted = 0;
        h = 5;
        acc = 0;
        lasts = 0;
      end
      if (halted && o_cpu_run[i]) runs++;
      if (halt_cyc >= 0 && gap < 0 && o_rd_en[i])
        gap = cyc - halt_cyc;
      if (!halted && h >= 0 && o_cc[i] == 32'(h)) begin
        instr[i] = HALT;
        halted = 1;
        if (halt_cyc < 0) halt_cyc = cyc;
      end else begin
        instr[i] = halted ? 32'($urandom) : nohalt();
      end
      if (!rnd_ready) ready[i] = 1;
      else if (hold > 0) begin
        ready[i] = 0;
        hold--;
      end else if ($urandom_range(0, 15) == 0) begin
        ready[i] = 0;
        hold = 6;
      end else ready[i] = 1'($urandom_range(0, 1));
      if (!rst_used && o_valid[i] &&
          o_addr[i] == 9'(rst_addr)) begin
        rstn[i] = 0;
        ready[i] = 0;
        rst_used = 1;
        rst_pend = 1;
      end
      if (o_valid[i] && ready[i] && rstn[i]) begin
        acc++;
        if (o_last[i]) lasts++;
      end
      step();
      cyc++;
    end
    chk({tag, "_budget"}, i, (cyc < 20000), 1);
    chk({tag, "_done"}, i, o_done[i], 1);
    chk({tag, "_timeout"}, i, o_to[i], exp_to);
    chk({tag, "_cc_end"}, i, o_cc[i], exp_cc);
    chk({tag, "_words"}, i, acc, exp_words);
    chk({tag, "_last_cnt"}, i, lasts, (exp_words > 0) ? 1 : 0);
    if (exp_gap >= 0) chk({tag, "_rd_gap"}, i, gap, exp_gap);
    if (exp_runs >= 0) chk({tag, "_drain_run"}, i, runs, exp_runs);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit hit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < 512; a++) ram[a] = $urandom;
    for (int i = 0; i < 2; i++) begin
      rstn[i] = 0;
      ready[i] = 0;
      instr[i] = '0;
      rdata[i] = '0;
    end
    step();
    step();
    scn(0, "a_basic", 19, 0, -1, 512, 20, 0, 11, 10);
    scn(0, "a_tmo", -1, 1, -1, 0, 600, 1, -1, -1);
    scn(0, "a_rst", $urandom_range(1, 40), 1, 100,
        512, 6, 0, 11, -1);
    scn(0, "a_edge", 599, 1, -1, 512, 600, 0, 11, -1);
    rstn[0] = 0;
    scn(1, "b_basic", 7, 1, -1, 4, 8, 0, 1, 0);
    scn(1, "b_tmo", -1, 0, -1, 0, 50, 1, -1, -1);
    scn(1, "b_edge", 49, 1, -1, 4, 50, 0, 1, -1);
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/halt_dump_ctrl.md
HALT_DUMP_CTRL -- requirements
Module: halt_dump_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DATA_W, 32, data word width
- ADDR_W, 9, dump address width
- DUMP_WORDS, 512, words dumped, 1..2^ADDR_W
- DRAIN_CYCLES, 10, pipeline-drain cycles after halt, 0..255
- MAX_CYCLES, 600, RUN cycle limit; 0 disables timeout
- HALT_WORD, 32'hFFFFFFFF, halt sentinel instruction
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- CLOCK  in  1  single clock, rising edge
- RESET  in  1  synchronous, active-low reset
- instr_f  in  32  fetch-stage instruction from CPU
- cpu_run  out  1  CPU advance enable
- mem_rd_en  out  1  data-RAM read strobe
- mem_rd_addr  out  ADDR_W  data-RAM read word address
- mem_rd_data  in  DATA_W  read data, valid one cycle after mem_rd_en
- dump_valid  out  1  dump word available
- dump_ready  in  1  consumer accepts word
- dump_data  out  DATA_W  dumped word
- dump_addr  out  ADDR_W  address of dump_data
- dump_last  out  1  dump_data is final word
- done  out  1  sequence complete, sticky
- timeout  out  1  MAX_CYCLES reached without halt, sticky
- cycle_count  out  32  RUN cycles elapsed, saturating

Function
REQ-003 FSM states SHALL be RUN, DRAIN, DUMP_RD, DUMP_CAP, DUMP_OUT, DONE; all transitions on rising CLOCK.
REQ-004 RUN: cpu_run=1; cycle_count increments each cycle, saturating at 2^32-1.
REQ-005 RUN, instr_f==HALT_WORD sampled: go to DRAIN with drain counter=DRAIN_CYCLES, or DUMP_RD with address 0 if DRAIN_CYCLES==0.
REQ-006 RUN, MAX_CYCLES!=0 and cycle_count reaches MAX_CYCLES-1 in that cycle, no halt: go to DONE, set timeout=1; no dump occurs.
REQ-007 Halt and timeout in the same cycle: halt wins, timeout stays 0.
REQ-008 DRAIN: cpu_run=1, counter decrements; when counter reaches 1, go to DUMP_RD with address 0; cycle_count frozen; instr_f ignored.
REQ-009 cpu_run SHALL be 0 in DUMP_RD, DUMP_CAP, DUMP_OUT, DONE.
REQ-010 DUMP_RD: mem_rd_en=1, mem_rd_addr=current address, one cycle, then DUMP_CAP.
REQ-011 DUMP_CAP: register mem_rd_data into dump_data and address into dump_addr; go to DUMP_OUT.
REQ-012 DUMP_OUT: dump_valid=1; dump_data, dump_addr, dump_last held stable until dump_valid&&dump_ready.
REQ-013 dump_last=1 iff dump_addr==DUMP_WORDS-1, valid only with dump_valid.
REQ-014 Accept (valid&&ready) of non-last word: address+1, go to DUMP_RD; of last word: go to DONE. Minimum 3 cycles per word.
REQ-015 dump_valid SHALL NOT depend combinationally on dump_ready.
REQ-016 DONE: done=1, all strobes 0, terminal until reset; instr_f and dump_ready ignored.
REQ-017 mem_rd_en SHALL be 0 outside DUMP_RD; mem_rd_addr SHALL never exceed DUMP_WORDS-1.

Reset
REQ-018 RESET low at a rising edge SHALL, from any state including mid-drain or mid-dump, force RUN with cycle_count=0, drain counter=0, address=0.
REQ-019 During and after reset: cpu_run=1; mem_rd_en, dump_valid, dump_last, done, timeout=0; dump_data, dump_addr, mem_rd_addr=0.

Verification
REQ-020 Halt at cycle 20, DRAIN_CYCLES=10, dump_ready=1 -> cpu_run=1 exactly 10 cycles after halt; 512 words addr 0..511 in order matching RAM; dump_last only on 511; done after word 511; cycle_count=20.
REQ-021 Never halt, MAX_CYCLES=600 -> timeout=1, done=1 after 600 RUN cycles; mem_rd_en never asserted.
REQ-022 dump_ready toggled randomly/held low 7 cycles -> dump_data/dump_addr stable while valid&&!ready; no word lost or duplicated.
REQ-023 DRAIN_CYCLES=0, DUMP_WORDS=4 -> DUMP_RD on cycle after halt; words 0..3; done after 4th accept.
REQ-024 RESET low during DUMP_OUT at addr 100 -> next cycle RUN, cpu_run=1, dump_valid=0, cycle_count=0; second halt restarts dump at addr 0.
REQ-025 Halt sentinel on cycle MAX_CYCLES-1 -> DRAIN entered, timeout=0, full dump completes.
